lsys_symbol_gen: RTL and testbench
==================================

// Module: lsys_symbol_gen
// PURPOSE
//  Consumes the 3-bit L-system select driven by the lsystem PIO and expands the chosen grammar to a
//  requested iteration depth. Expansion is depth-first on a hardware stack; turtle symbols stream out
//  over a valid/ready handshake to the downstream turtle/line-drawing stage. One run per start pulse.
// PARAMETERS
//  MAX_DEPTH     7   deepest supported iteration; stack holds MAX_DEPTH+1 frames
//  DEPTH_W       3   width of iter_depth
//  MAX_RULE_LEN  24  longest rule/axiom body in symbols; sets idx width
// PORTS
//  clk         in   1        system clock
//  reset_n     in   1        synchronous, active-low reset
//  lsys_sel    in   3        grammar select (from lsystem PIO out_port); sampled on start
//  iter_depth  in   DEPTH_W  iterations; sampled on start, clamped to MAX_DEPTH
//  start       in   1        begin a run; honoured only in IDLE
//  busy        out  1        high from the cycle after an accepted start until done
//  done        out  1        one-cycle pulse at end of run
//  sym_valid   out  1        sym_data holds a symbol
//  sym_ready   in   1        downstream accepts symbol when valid&ready
//  sym_data    out  3        0=F draw, 1=+ left, 2=- right, 3=[ push, 4=] pop
// BEHAVIOUR
//  - Reset: FSM->IDLE, busy=0, done=0, sym_valid=0, sym_data=0, stack pointer=0. Mid-run reset aborts.
//  - FSM: IDLE -> LOAD -> STEP <-> EMIT -> FIN -> IDLE.
//  - IDLE: on start, latch sel/depth. If sel >= NUM_SYSTEMS, go to FIN with no symbols. Otherwise go to
//    LOAD and push frame {rule=AXIOM(sel), idx=0, level=0}.
//  - STEP (one ROM read per cycle) on top frame, symbol s=body[idx]:
//    - idx==len: pop the frame. If the stack is now empty, go to FIN.
//    - s in {F,X} and level<depth: idx++, then push {rule(s), 0, level+1}.
//    - s==X at level==depth: idx++ and emit nothing.
//    - Otherwise: idx++, load sym_data=s, sym_valid=1, go to EMIT.
//  - EMIT: hold sym_valid and sym_data stable until sym_ready. On the handshake, drop sym_valid and
//    return to STEP.
//  - Outputs are registered, with no combinational path from sym_ready to sym_valid.
//  - FIN: done=1 for one cycle and busy drops in the same cycle; the next state is IDLE.
//  - start while busy is ignored. lsys_sel/iter_depth changes mid-run are ignored (latched copies used).
//  - Stack never overflows: pushes occur only when level<depth<=MAX_DEPTH.
// CONFIGURATION
//  LSYS_SYM_COUNT_EN defined:
//    - adds output sym_count[31:0], reset to 0 and cleared on an accepted start.
//    - sym_count increments on each valid&ready handshake and holds after done.
//  LSYS_SYM_COUNT_EN undefined: the port and the counter are absent, with identical behaviour otherwise.
// STRUCTURE
//  Package lsys_pkg:
//    - symbol encodings (SYM_F..SYM_POP, SYM_X=5), NUM_SYSTEMS=4, rule id enum {AXIOM,RULE_F,RULE_X}.
//    - constant rule tables:
//      sel0 Koch     ax F   F->F+F-F-F+F
//      sel1 plant    ax X   X->F+[[X]-X]-F[-FX]+X  F->FF
//      sel2 tree     ax F   F->F[+F]F[-F]F
//      sel3 bush     ax F   F->FF-[-F+F+F]+[+F-F-F]
//    - Absent X rules have length 0.
//  Sub-module lsys_rule_rom: combinational lookup (sel, rule, idx) -> (sym, len).
//  The stack and FSM stay in lsys_symbol_gen.
// TESTING
//  1 sel=0, depth=0, start, ready=1 -> exactly one symbol F(0), then done pulse, busy=0.
//  2 sel=0, depth=1 -> sequence 0,1,0,2,0,2,0,1,0 (9 symbols), then done.
//  3 sel=0, depth=2 -> 49 symbols: 25 F, 24 turns; first 9 match scenario 2.
//  4 sel=1, depth=1 -> 0,1,3,3,4,2,4,2,0,3,2,0,4,1 (14 symbols; X dropped).
//  5 sel=0, depth=1, sym_ready low 5 cycles on every symbol -> sym_data stable while valid;
//    same 9-symbol sequence delivered.
//  6 sel=5 -> done 2 cycles after start, no sym_valid.
//    Mid-run reset_n=0 -> all outputs 0 next cycle.
//    start while busy -> ignored; sequence unaltered.

Source files
------------

// File: rtl/lsys_pkg.sv
// lsys_pkg: symbol/rule encodings, sizing constants and grammar tables shared by the L-system expander
package lsys_pkg;
  localparam int MAX_DEPTH = 7;
  localparam int DEPTH_W = 3;
  localparam int MAX_RULE_LEN = 24;
  localparam int NUM_SYSTEMS = 4;
  localparam int IDX_W = $clog2(MAX_RULE_LEN + 1);
  localparam int STK_N = MAX_DEPTH + 1;
  localparam int TP_W = $clog2(STK_N);
  localparam int SP_W = TP_W + 1;
  localparam int BODY_W = 8 * MAX_RULE_LEN;
  typedef enum logic [2:0] {SYM_F, SYM_PLUS, SYM_MINUS, SYM_PUSH, SYM_POP, SYM_X} sym_t;
  typedef enum logic [1:0] {AXIOM, RULE_F, RULE_X} rule_t;
  typedef enum logic [2:0] {IDLE, LOAD, STEP, EMIT, FIN} state_t;
  typedef struct packed {
    rule_t rule;
    logic [IDX_W-1:0] idx;
    logic [DEPTH_W-1:0] level;
  } frame_t;
  // Bodies are ASCII, right-aligned: the last symbol sits in bits [7:0]
  localparam logic [BODY_W-1:0] BODY [NUM_SYSTEMS][3] = '{
    '{BODY_W'("F"), BODY_W'("F+F-F-F+F"), BODY_W'(0)},
    '{BODY_W'("X"), BODY_W'("FF"), BODY_W'("F+[[X]-X]-F[-FX]+X")},
    '{BODY_W'("F"), BODY_W'("F[+F]F[-F]F"), BODY_W'(0)},
    '{BODY_W'("F"), BODY_W'("FF-[-F+F+F]+[+F-F-F]"), BODY_W'(0)}
  };
  localparam logic [IDX_W-1:0] LEN [NUM_SYSTEMS][3] = '{
    '{5'd1, 5'd9, 5'd0},
    '{5'd1, 5'd2, 5'd18},
    '{5'd1, 5'd11, 5'd0},
    '{5'd1, 5'd20, 5'd0}
  };
  function automatic rule_t rule_for(sym_t s);
    return s == SYM_X ? RULE_X : RULE_F;
  endfunction
endpackage

// File: rtl/lsys_symbol_gen_if.sv
// lsys_symbol_gen_if: symbol stream handshake from the expander to the turtle stage
interface lsys_symbol_gen_if;
  logic sym_valid;
  logic sym_ready;
  logic [2:0] sym_data;
  modport master(output sym_valid, output sym_data, input sym_ready);
  modport slave(input sym_valid, input sym_data, output sym_ready);
endinterface

// File: rtl/lsys_rule_rom.sv
// lsys_rule_rom: combinational (grammar, rule, index) -> (symbol, rule length) lookup
module lsys_rule_rom
  import lsys_pkg::*;
(
  input  logic [1:0] sel,
  input  rule_t rule,
  input  logic [IDX_W-1:0] idx,
  output sym_t sym,
  output logic [IDX_W-1:0] len
);
  logic [BODY_W-1:0] body;
  logic [IDX_W-1:0] pos;
  logic [7:0] ch;
  assign body = BODY[sel][rule];
  assign len = LEN[sel][rule];
  assign pos = len - idx - IDX_W'(1);
  assign ch = 8'(body >> {pos, 3'b000});
  always_comb
    sym = ch == "+" ? SYM_PLUS
        : ch == "-" ? SYM_MINUS
        : ch == "[" ? SYM_PUSH
        : ch == "]" ? SYM_POP
        : ch == "X" ? SYM_X
        : SYM_F;
endmodule

// File: rtl/lsys_symbol_gen.sv
// lsys_symbol_gen: depth-first L-system expansion on a frame stack, streaming turtle symbols.
// Defining LSYS_SYM_COUNT_EN adds the sym_count handshake counter.
module lsys_symbol_gen
  import lsys_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
`ifdef LSYS_SYM_COUNT_EN
  output logic [31:0] sym_count,
`endif
  input  logic [2:0] lsys_sel,
  input  logic [DEPTH_W-1:0] iter_depth,
  input  logic start,
  output logic busy,
  output logic done,
  lsys_symbol_gen_if.master sym
);
  state_t state, state_d;
  frame_t stack [STK_N];
  frame_t top;
  logic [SP_W-1:0] sp;
  logic [TP_W-1:0] tp;
  logic [1:0] sel_q;
  logic [DEPTH_W-1:0] depth_q;
  sym_t rsym;
  logic [IDX_W-1:0] rlen;
  logic at_end, expand, emit, busy_d, done_d, valid_d;

  assign tp = TP_W'(sp - SP_W'(1));
  assign top = stack[tp];
  assign at_end = top.idx == rlen;
  assign expand = (rsym == SYM_F || rsym == SYM_X) && top.level < depth_q;
  assign emit = !at_end && !expand && rsym != SYM_X;

  lsys_rule_rom u_rom (.sel(sel_q), .rule(top.rule), .idx(top.idx), .sym(rsym), .len(rlen));

  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sym.sym_valid <= 1'b0;
    end else begin
      state <= state_d;
      busy <= busy_d;
      done <= done_d;
      sym.sym_valid <= valid_d;
    end

  always_comb
    state_d = state == IDLE ? (start ? (lsys_sel >= 3'(NUM_SYSTEMS) ? FIN : LOAD) : IDLE)
            : state == LOAD ? STEP
            : state == STEP ? (at_end ? (sp == SP_W'(1) ? FIN : STEP) : emit ? EMIT : STEP)
            : state == EMIT ? (sym.sym_ready ? STEP : EMIT)
            : IDLE;

  always_comb begin
    busy_d = state == IDLE ? start : state != FIN;
    done_d = state == FIN;
    valid_d = (state == STEP && emit) || (state == EMIT && !sym.sym_ready);
  end

  // One ROM read per STEP: pop on exhaustion, else advance idx and maybe push a child frame
  always_ff @(posedge clk)
    if (!reset_n) begin
      sp <= '0;
      sel_q <= '0;
      depth_q <= '0;
      sym.sym_data <= '0;
    end else if (state == IDLE && start) begin
      sel_q <= lsys_sel[1:0];
      depth_q <= {1'b0, iter_depth} > (DEPTH_W+1)'(MAX_DEPTH) ? DEPTH_W'(MAX_DEPTH) : iter_depth;
    end else if (state == LOAD) begin
      stack[0] <= '{AXIOM, '0, '0};
      sp <= SP_W'(1);
    end else if (state == STEP) begin
      if (at_end) sp <= sp - SP_W'(1);
      else begin
        stack[tp].idx <= top.idx + IDX_W'(1);
        if (expand) begin
          stack[TP_W'(sp)] <= '{rule_for(rsym), '0, top.level + DEPTH_W'(1)};
          sp <= sp + SP_W'(1);
        end
        if (emit) sym.sym_data <= rsym;
      end
    end

`ifdef LSYS_SYM_COUNT_EN
  always_ff @(posedge clk)
    if (!reset_n || (state == IDLE && start)) sym_count <= '0;
    else if (state == EMIT && sym.sym_ready) sym_count <= sym_count + 32'd1;
`endif
endmodule

// File: tb/tb_lsys_symbol_gen.sv
// tb_lsys_symbol_gen: testbench for lsys_symbol_gen; define LSYS_SYM_COUNT_EN to cover sym_count
`timescale 1ns/1ps
module tb_lsys_symbol_gen;
  import lsys_pkg::*;
  localparam int LIMIT = 20000;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic [2:0] lsys_sel = '0;
  logic [DEPTH_W-1:0] iter_depth = '0;
`ifdef LSYS_SYM_COUNT_EN
  logic [31:0] sym_count;
`endif
  lsys_symbol_gen_if sif();
  int total = 0;
  int passed = 0;
  int got[$];
  int exp[$];
  int done_cyc, valid_seen, unstable, busy1, busy_at_done, done_next;

  always #5 clk = ~clk;

  lsys_symbol_gen dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef LSYS_SYM_COUNT_EN
    .sym_count(sym_count),
`endif
    .lsys_sel(lsys_sel),
    .iter_depth(iter_depth),
    .start(start),
    .busy(busy),
    .done(done),
    .sym(sif)
  );

  function automatic string rule_of(int sel, byte c);
    if (c == "F") begin
      if (sel == 0) return "F+F-F-F+F";
      if (sel == 1) return "FF";
      if (sel == 2) return "F[+F]F[-F]F";
      return "FF-[-F+F+F]+[+F-F-F]";
    end
    if (c == "X" && sel == 1) return "F+[[X]-X]-F[-FX]+X";
    return "";
  endfunction

  // Parallel rewriting `depth` times, then X dropped and turtle characters coded
  function automatic void model(int sel, int depth);
    string s, n, t;
    byte c;
    s = sel == 1 ? "X" : "F";
    t = " ";
    for (int d = 0; d < depth; d++) begin
      n = "";
      for (int i = 0; i < s.len(); i++) begin
        c = s.getc(i);
        if (c == "F" || c == "X") n = {n, rule_of(sel, c)};
        else begin
          t.putc(0, c);
          n = {n, t};
        end
      end
      s = n;
    end
    exp.delete();
    for (int i = 0; i < s.len(); i++)
      case (s.getc(i))
        "F": exp.push_back(0);
        "+": exp.push_back(1);
        "-": exp.push_back(2);
        "[": exp.push_back(3);
        "]": exp.push_back(4);
        default: ;
      endcase
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < got.size() || i < exp.size(); i++)
      if (i >= got.size() || i >= exp.size() || got[i] != exp[i]) return i;
    return -1;
  endfunction

  function automatic int at(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction

  // mode 0: ready always high, 1: random ready, 2: ready held low 5 cycles per symbol
  task automatic run(input int sel, input int depth, input int mode, input bit poke);
    int w;
    logic [2:0] held;
    got.delete();
    done_cyc = -1;
    valid_seen = 0;
    unstable = 0;
    w = 0;
    held = '0;
    @(negedge clk);
    lsys_sel = 3'(sel);
    iter_depth = DEPTH_W'(depth);
    start = 1'b1;
    sif.sym_ready = 1'b0;
    for (int c = 1; c <= LIMIT && done_cyc < 0; c++) begin
      @(negedge clk);
      start = poke && c == 3;
      if (poke && c == 3) begin
        lsys_sel = 3'd3;
        iter_depth = '0;
      end
      if (c == 1) busy1 = busy;
      if (sif.sym_valid) begin
        valid_seen++;
        if (mode == 2) begin
          if (w == 0) held = sif.sym_data;
          else if (sif.sym_data !== held) unstable++;
          sif.sym_ready = w == 5;
          w = w == 5 ? 0 : w + 1;
        end else sif.sym_ready = mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
        if (sif.sym_ready) got.push_back(int'(sif.sym_data));
      end else begin
        sif.sym_ready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
        w = 0;
      end
      if (done) begin
        done_cyc = c;
        busy_at_done = busy;
      end
    end
    @(negedge clk);
    done_next = done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sif.sym_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
    total++; if (sif.sym_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", sif.sym_valid); else passed++;
    total++; if (sif.sym_data !== 3'd0) $display("FAIL reset_data got %0d want 0", sif.sym_data); else passed++;
`ifdef LSYS_SYM_COUNT_EN
    total++; if (sym_count !== 32'd0) $display("FAIL reset_count got %0d want 0", sym_count); else passed++;
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_koch_d0();
    run(0, 0, 0, 0);
    total++; if (done_cyc < 0) $display("FAIL koch_d0_timeout got no done want done"); else passed++;
    total++; if (got.size() != 1 || got[0] != 0) $display("FAIL koch_d0_seq got len %0d first %0d want len 1 first 0", got.size(), at(got, 0)); else passed++;
    total++; if (busy1 !== 1) $display("FAIL koch_d0_busy got %0d want 1", busy1); else passed++;
    total++; if (busy_at_done !== 0) $display("FAIL koch_d0_busy_at_done got %0d want 0", busy_at_done); else passed++;
    total++; if (done_next !== 0) $display("FAIL koch_d0_done_pulse got %0d want 0", done_next); else passed++;
  endtask

  task automatic test_koch_d1();
    int d;
    exp = '{0, 1, 0, 2, 0, 2, 0, 1, 0};
    run(0, 1, 0, 0);
    d = first_diff();
    total++; if (d >= 0) $display("FAIL koch_d1_seq idx %0d got %0d want %0d", d, at(got, d), at(exp, d)); else passed++;
`ifdef LSYS_SYM_COUNT_EN
    total++; if (sym_count !== 32'd9) $display("FAIL koch_d1_count got %0d want 9", sym_count); else passed++;
`endif
  endtask

  task automatic test_koch_d2();
    int d, nf;
    int head[$];
    head = '{0, 1, 0, 2, 0, 2, 0, 1, 0};
    run(0, 2, 0, 0);
    nf = 0;
    foreach (got[i]) if (got[i] == 0) nf++;
    total++; if (got.size() != 49) $display("FAIL koch_d2_len got %0d want 49", got.size()); else passed++;
    total++; if (nf != 25) $display("FAIL koch_d2_fcount got %0d want 25", nf); else passed++;
    d = -1;
    for (int i = 8; i >= 0; i--) if (at(got, i) != head[i]) d = i;
    total++; if (d >= 0) $display("FAIL koch_d2_head idx %0d got %0d want %0d", d, at(got, d), head[d]); else passed++;
    model(0, 2);
    d = first_diff();
    total++; if (d >= 0) $display("FAIL koch_d2_seq idx %0d got %0d want %0d", d, at(got, d), at(exp, d)); else passed++;
  endtask

  task automatic test_plant_d1();
    int d;
    exp = '{0, 1, 3, 3, 4, 2, 4, 2, 0, 3, 2, 0, 4, 1};
    run(1, 1, 0, 0);
    d = first_diff();
    total++; if (d >= 0) $display("FAIL plant_d1_seq idx %0d got %0d want %0d", d, at(got, d), at(exp, d)); else passed++;
  endtask

  task automatic test_stall();
    int d;
    exp = '{0, 1, 0, 2, 0, 2, 0, 1, 0};
    run(0, 1, 2, 0);
    total++; if (unstable != 0) $display("FAIL stall_stable got %0d changes want 0", unstable); else passed++;
    total++; if (valid_seen != 54) $display("FAIL stall_valid_cycles got %0d want 54", valid_seen); else passed++;
    d = first_diff();
    total++; if (d >= 0) $display("FAIL stall_seq idx %0d got %0d want %0d", d, at(got, d), at(exp, d)); else passed++;
  endtask

  task automatic test_bad_sel();
    run(5, 0, 0, 0);
    total++; if (done_cyc != 2) $display("FAIL bad_sel_done_cycle got %0d want 2", done_cyc); else passed++;
    total++; if (valid_seen != 0) $display("FAIL bad_sel_valid got %0d want 0", valid_seen); else passed++;
    total++; if (busy1 !== 1) $display("FAIL bad_sel_busy got %0d want 1", busy1); else passed++;
    total++; if (busy_at_done !== 0) $display("FAIL bad_sel_busy_at_done got %0d want 0", busy_at_done); else passed++;
  endtask

  task automatic test_mid_reset();
    int d;
    @(negedge clk);
    lsys_sel = 3'd0;
    iter_depth = DEPTH_W'(2);
    start = 1'b1;
    sif.sym_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %0b want 0", busy); else passed++;
    total++; if (sif.sym_valid !== 1'b0) $display("FAIL midrst_valid got %0b want 0", sif.sym_valid); else passed++;
    total++; if (sif.sym_data !== 3'd0) $display("FAIL midrst_data got %0d want 0", sif.sym_data); else passed++;
    total++; if (done !== 1'b0) $display("FAIL midrst_done got %0b want 0", done); else passed++;
    reset_n = 1'b1;
    exp = '{0, 1, 0, 2, 0, 2, 0, 1, 0};
    run(0, 1, 0, 0);
    d = first_diff();
    total++; if (d >= 0) $display("FAIL midrst_rerun idx %0d got %0d want %0d", d, at(got, d), at(exp, d)); else passed++;
  endtask

  task automatic test_start_while_busy();
    int d;
    exp = '{0, 1, 0, 2, 0, 2, 0, 1, 0};
    run(0, 1, 1, 1);
    d = first_diff();
    total++; if (d >= 0) $display("FAIL busy_start_seq idx %0d got %0d want %0d", d, at(got, d), at(exp, d)); else passed++;
  endtask

  task automatic test_random();
    int sel, depth, d;
    for (int n = 0; n < 12; n++) begin
      sel = $urandom_range(0, 3);
      depth = sel == 3 ? $urandom_range(0, 2) : $urandom_range(0, 3);
      model(sel, depth);
      run(sel, depth, 1, 0);
      total++; if (done_cyc < 0) $display("FAIL rand%0d_timeout sel %0d depth %0d got no done want done", n, sel, depth); else passed++;
      d = first_diff();
      total++; if (d >= 0) $display("FAIL rand%0d_seq sel %0d depth %0d idx %0d got %0d want %0d", n, sel, depth, d, at(got, d), at(exp, d)); else passed++;
`ifdef LSYS_SYM_COUNT_EN
      total++; if (sym_count !== 32'(exp.size())) $display("FAIL rand%0d_count got %0d want %0d", n, sym_count, exp.size()); else passed++;
`endif
    end
  endtask

  initial begin
    sif.sym_ready = 1'b0;
    test_reset();
    test_koch_d0();
    test_koch_d1();
    test_koch_d2();
    test_plant_d1();
    test_stall();
    test_bad_sel();
    test_mid_reset();
    test_start_while_busy();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
